stage_memory: RTL and testbench
===============================

Name: stage_memory

Overview:
Pipeline stage directly downstream of execute. It consumes execute's registered outputs: valid, pc, ALU result/address, store data, access controls and destination register. It performs loads and stores over a single-outstanding request/acknowledge data bus, aligning store data and extending load data. It stalls execute while an access is pending, and registers results for the writeback stage.

Parameters:
TIMEOUT, 16, ack wait-cycle limit before a bus-timeout fault; 0 disables the timeout.

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-high reset
mem_valid  in  1  execute has an instruction in this stage; held while mem_stall
mem_pc  in  32  instruction pc
mem_data0  in  32  ALU result; the byte address for loads/stores
mem_data1  in  32  store source data (rs2)
mem_read  in  1  load
mem_write  in  1  store; never asserted together with mem_read
mem_extend  in  1  load: 1=sign-extend, 0=zero-extend
mem_width  in  2  0=byte, 1=half, 2=word, 3=reserved
wb_reg  in  5  destination register; 0 = none
mem_stall  out  1  hold execute and its output registers
mem_forward_valid  out  1  mem_valid & ~mem_read
mem_forward_data  out  32  mem_data0, for bypass into decode
dbus_req  out  1  bus request
dbus_we  out  1  1=write
dbus_addr  out  32  {mem_data0[31:2],2'b00}
dbus_be  out  4  byte enables
dbus_wdata  out  32  lane-replicated store data
dbus_ack  in  1  request completes this cycle; rdata valid this cycle
dbus_rdata  in  32  read word
wb_valid  out  1  registered result valid
wb_pc  out  32  registered pc
wb_data  out  32  load result, or mem_data0 for non-loads
wb_reg_r  out  5  registered destination
wb_fault  out  2  0=none, 1=misaligned, 2=bus timeout

Behaviour:
- Access is mem_read|mem_write.
- Misaligned if any of:
  - width 1 and addr[0]=1
  - width 2 and addr[1:0]!=0
  - width 3
- dbus_req = mem_valid & access & ~misaligned. Driven combinationally; held until ack or timeout.
- dbus_we = mem_write.
- Byte enables:
  - byte: 4'b0001<<addr[1:0]
  - half: 4'b0011<<addr[1:0]
  - word: 4'b1111
- Store data: byte replicates {4{d[7:0]}}; half replicates {2{d[15:0]}}; word passes d unchanged.
- Load lane select:
  - byte: rdata>>(8*addr[1:0]), bits [7:0]
  - half: addr[1] ? rdata[31:16] : rdata[15:0]
  - Then sign- or zero-extend to 32 per mem_extend.
- FSM states: IDLE, BUSY. Counter cnt, width clog2(TIMEOUT+1).
  - IDLE, dbus_req & ~ack: go BUSY, cnt<=1.
  - IDLE, dbus_req & ack: complete; stay IDLE with zero wait and no stall.
  - BUSY & ack: complete, go IDLE, cnt<=0.
  - BUSY & ~ack & TIMEOUT!=0 & cnt==TIMEOUT: timeout completion, fault=2, wb_data=0, go IDLE. dbus_req is still asserted that cycle; the bus must treat the drop as abandonment.
  - BUSY otherwise: cnt++, saturating.
- mem_stall = dbus_req & ~complete, where complete = ack | timeout.
- Misaligned and non-access instructions complete in their first cycle: no bus activity, no stall.
- Output register, updated every cycle:
  - wb_valid <= mem_valid & ~mem_stall
  - wb_pc, wb_data, wb_reg_r, wb_fault update only when mem_valid & ~mem_stall; otherwise they hold.
- Faulting instructions: wb_valid=1, wb_fault set, wb_reg_r forced to 0 so no register write.
- Latency: 1 cycle to wb with zero-wait ack; N wait cycles add N cycles of mem_stall.
- Each access produces exactly one wb_valid pulse.
- Reset, async at any time including BUSY: state=IDLE, cnt=0, wb_valid=0, wb_pc=0, wb_data=0, wb_reg_r=0, wb_fault=0. dbus_req follows mem_valid, which execute clears on its own reset.
- Assertion (non-synthesis): mem_read&mem_write never both 1 when mem_valid.
- Debug print (non-synthesis): "stage_memory: stalling" each cycle mem_stall=1.

Decomposition:
- defines.vh gains: MEMW_BYTE/HALF/WORD (2-bit), FAULT_NONE/MISALIGN/TIMEOUT (2-bit), MEMSTATE_IDLE/BUSY.
- One sub-module, mem_align: combinational lane steering (be, wdata replication, load select and extend). Reused by any future instruction-side unaligned fetch.

Test Plan:
- Word store addr 0x100, data 0xDEADBEEF, ack same cycle -> dbus_be=1111, wdata=0xDEADBEEF, mem_stall never high, wb_valid pulse next cycle, wb_data=0x100.
- Byte load signed addr 0x203, rdata 0x80FF1234, ack after 3 waits -> mem_stall high 3 cycles, be=1000, wb_data=0xFFFFFF80. Repeat unsigned -> 0x00000080.
- Half store addr 0x12, data 0x0000ABCD -> be=1100, wdata=0xABCDABCD. Half load signed addr 0x12, rdata 0x7FFF0000 -> wb_data=0x00007FFF.
- Word load addr 0x101 -> no dbus_req, no stall, wb_fault=1, wb_reg_r=0.
- TIMEOUT=4, load with no ack -> mem_stall for 4 cycles, then wb_fault=2, wb_data=0, FSM back to IDLE, next access proceeds normally.
- Reset asserted while BUSY -> wb_valid=0, state IDLE on the same edge. Release, then a back-to-back ALU op and load -> correct forward_data and one wb pulse each.

Source files
------------

// File: rtl/stage_memory_pkg.sv
// Shared constants for the memory stage: access widths,
// fault codes and the bus-wait state encoding.
package stage_memory_pkg;

    localparam logic [1:0] MEMW_BYTE = 2'd0;
    localparam logic [1:0] MEMW_HALF = 2'd1;
    localparam logic [1:0] MEMW_WORD = 2'd2;

    localparam logic [1:0] FAULT_NONE     = 2'd0;
    localparam logic [1:0] FAULT_MISALIGN = 2'd1;
    localparam logic [1:0] FAULT_TIMEOUT  = 2'd2;

    typedef enum logic {
        MEMSTATE_IDLE = 1'b0,
        MEMSTATE_BUSY = 1'b1
    } memstate_e;

    // Width 3 is reserved and always treated as misaligned.
    function automatic logic is_misaligned(
        input logic [1:0] width,
        input logic [1:0] off
    );
        return (width == MEMW_HALF && off[0])
            || (width == MEMW_WORD && off != 2'b00)
            || (width == 2'd3);
    endfunction

endpackage

// File: rtl/stage_memory_align.sv
// Combinational byte-lane steering: byte enables, store-data
// replication, load lane select and sign/zero extension.
// Ports: off_i (addr[1:0]), width_i, extend_i, sdata_i (store
// source), rdata_i (bus word) -> be_o, wdata_o, ldata_o.
module stage_memory_align
    import stage_memory_pkg::*;
(
    input  logic [1:0]  off_i,
    input  logic [1:0]  width_i,
    input  logic        extend_i,
    input  logic [31:0] sdata_i,
    input  logic [31:0] rdata_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] ldata_o
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    assign lane_b = rdata_i[{off_i, 3'b000} +: 8];
    assign lane_h = off_i[1] ? rdata_i[31:16] : rdata_i[15:0];

    always_comb begin
        be_o    = 4'b0000;
        wdata_o = sdata_i;
        ldata_o = 32'h0;
        case (width_i)
            MEMW_BYTE: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{sdata_i[7:0]}};
                ldata_o = {{24{extend_i & lane_b[7]}}, lane_b};
            end
            MEMW_HALF: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{sdata_i[15:0]}};
                ldata_o = {{16{extend_i & lane_h[15]}}, lane_h};
            end
            MEMW_WORD: begin
                be_o    = 4'b1111;
                wdata_o = sdata_i;
                ldata_o = rdata_i;
            end
            default: begin
                be_o    = 4'b0000;
                wdata_o = sdata_i;
                ldata_o = 32'h0;
            end
        endcase
    end

endmodule

// File: rtl/stage_memory.sv
// Memory pipeline stage: drives a single-outstanding data bus,
// stalls execute while waiting for ack, registers results.
// Ports: execute inputs (mem_*, wb_reg), stall/forward outputs,
// dbus_* request/ack bus, registered wb_* results.
module stage_memory
    import stage_memory_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_valid,
    input  logic [31:0] mem_pc,
    input  logic [31:0] mem_data0,
    input  logic [31:0] mem_data1,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic        mem_extend,
    input  logic [1:0]  mem_width,
    input  logic [4:0]  wb_reg,
    output logic        mem_stall,
    output logic        mem_forward_valid,
    output logic [31:0] mem_forward_data,
    output logic        dbus_req,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_ack,
    input  logic [31:0] dbus_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_pc,
    output logic [31:0] wb_data,
    output logic [4:0]  wb_reg_r,
    output logic [1:0]  wb_fault
);

    localparam int CW =
        (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] CNT_MAX = '1;
    localparam logic [CW-1:0] CNT_TMO = CW'(TIMEOUT);

    memstate_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic        access;
    logic        misaligned;
    logic        ack_done;
    logic        tmo;
    logic        fire;
    logic [31:0] ldata;

    logic        wb_valid_q;
    logic [31:0] wb_pc_q, wb_pc_d;
    logic [31:0] wb_data_q, wb_data_d;
    logic [4:0]  wb_reg_q, wb_reg_d;
    logic [1:0]  wb_fault_q, wb_fault_d;

    assign access     = mem_read | mem_write;
    assign misaligned = access
                      & is_misaligned(mem_width, mem_data0[1:0]);

    assign dbus_req  = mem_valid & access & ~misaligned;
    assign dbus_we   = mem_write;
    assign dbus_addr = {mem_data0[31:2], 2'b00};

    assign mem_forward_valid = mem_valid & ~mem_read;
    assign mem_forward_data  = mem_data0;

    stage_memory_align u_align (
        .off_i    (mem_data0[1:0]),
        .width_i  (mem_width),
        .extend_i (mem_extend),
        .sdata_i  (mem_data1),
        .rdata_i  (dbus_rdata),
        .be_o     (dbus_be),
        .wdata_o  (dbus_wdata),
        .ldata_o  (ldata)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MEMSTATE_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ack_done = 1'b0;
        tmo      = 1'b0;
        unique case (state_q)
            MEMSTATE_IDLE: begin
                if (dbus_req) begin
                    if (dbus_ack) begin
                        ack_done = 1'b1;
                    end else begin
                        state_d = MEMSTATE_BUSY;
                        cnt_d   = CW'(1);
                    end
                end
            end
            MEMSTATE_BUSY: begin
                if (dbus_ack) begin
                    ack_done = 1'b1;
                    state_d  = MEMSTATE_IDLE;
                    cnt_d    = '0;
                end else if (TIMEOUT != 0 && cnt_q == CNT_TMO) begin
                    // Request stays high this cycle; the bus sees
                    // the following drop as abandonment.
                    tmo     = 1'b1;
                    state_d = MEMSTATE_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
        endcase
    end

    assign mem_stall = dbus_req & ~(ack_done | tmo);
    assign fire      = mem_valid & ~mem_stall;

    always_comb begin
        wb_fault_d = FAULT_NONE;
        if (misaligned) begin
            wb_fault_d = FAULT_MISALIGN;
        end else if (tmo) begin
            wb_fault_d = FAULT_TIMEOUT;
        end
        wb_pc_d   = mem_pc;
        wb_data_d = mem_read ? ldata : mem_data0;
        wb_reg_d  = wb_reg;
        // Faults suppress the register write.
        if (wb_fault_d != FAULT_NONE) begin
            wb_data_d = 32'h0;
            wb_reg_d  = 5'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wb_valid_q <= 1'b0;
            wb_pc_q    <= '0;
            wb_data_q  <= '0;
            wb_reg_q   <= '0;
            wb_fault_q <= FAULT_NONE;
        end else begin
            wb_valid_q <= fire;
            if (fire) begin
                wb_pc_q    <= wb_pc_d;
                wb_data_q  <= wb_data_d;
                wb_reg_q   <= wb_reg_d;
                wb_fault_q <= wb_fault_d;
            end
        end
    end

    assign wb_valid = wb_valid_q;
    assign wb_pc    = wb_pc_q;
    assign wb_data  = wb_data_q;
    assign wb_reg_r = wb_reg_q;
    assign wb_fault = wb_fault_q;

`ifndef SYNTHESIS
    a_rw_excl: assert property (
        @(posedge clk) disable iff (reset)
        mem_valid |-> !(mem_read && mem_write)
    ) else $error("stage_memory: read and write together");

    always @(posedge clk) begin
        if (mem_stall) $display("stage_memory: stalling");
    end
`endif

endmodule

// File: tb/tb_stage_memory.sv
// Bench for stage_memory: directed scenarios plus randomized
// accesses checked against a lane-level reference model.
module tb_stage_memory;

    localparam int TMO = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_valid;
    logic [31:0] mem_pc, mem_data0, mem_data1;
    logic        mem_read, mem_write, mem_extend;
    logic [1:0]  mem_width;
    logic [4:0]  wb_reg;
    logic        mem_stall, mem_forward_valid;
    logic [31:0] mem_forward_data;
    logic        dbus_req, dbus_we;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata;
    logic [3:0]  dbus_be;
    logic        dbus_ack;
    logic        wb_valid;
    logic [31:0] wb_pc, wb_data;
    logic [4:0]  wb_reg_r;
    logic [1:0]  wb_fault;

    int total = 0;
    int bad   = 0;

    stage_memory #(.TIMEOUT(TMO)) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_valid         (mem_valid),
        .mem_pc            (mem_pc),
        .mem_data0         (mem_data0),
        .mem_data1         (mem_data1),
        .mem_read          (mem_read),
        .mem_write         (mem_write),
        .mem_extend        (mem_extend),
        .mem_width         (mem_width),
        .wb_reg            (wb_reg),
        .mem_stall         (mem_stall),
        .mem_forward_valid (mem_forward_valid),
        .mem_forward_data  (mem_forward_data),
        .dbus_req          (dbus_req),
        .dbus_we           (dbus_we),
        .dbus_addr         (dbus_addr),
        .dbus_be           (dbus_be),
        .dbus_wdata        (dbus_wdata),
        .dbus_ack          (dbus_ack),
        .dbus_rdata        (dbus_rdata),
        .wb_valid          (wb_valid),
        .wb_pc             (wb_pc),
        .wb_data           (wb_data),
        .wb_reg_r          (wb_reg_r),
        .wb_fault          (wb_fault)
    );

    always #5 clk = ~clk;

    // Observations from the latest issue() call.
    logic        o_req, o_we, o_fv, o_hung;
    logic [3:0]  o_be;
    logic [31:0] o_wdata, o_addr, o_fd;
    int          o_stalls, o_wbv_stall;
    logic        o_wbv;
    logic [31:0] o_wpc, o_wdat;
    logic [4:0]  o_wreg;
    logic [1:0]  o_wf;

    function automatic int lane_size(input logic [1:0] w);
        return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : 4;
    endfunction

    function automatic logic f_mis(input logic [1:0] w,
                                   input logic [31:0] a);
        if (w == 2'd3) return 1'b1;
        return (a % lane_size(w)) != 0;
    endfunction

    function automatic logic [3:0] f_be(input logic [1:0] w,
                                        input logic [31:0] a);
        logic [3:0] be;
        int off, sz;
        off = int'(a[1:0]);
        sz  = lane_size(w);
        be  = '0;
        for (int k = 0; k < 4; k++)
            be[k] = (k >= off) && (k < off + sz);
        return be;
    endfunction

    function automatic logic [31:0] f_wd(input logic [1:0] w,
                                         input logic [31:0] d);
        logic [31:0] r;
        int sz;
        sz = lane_size(w);
        for (int k = 0; k < 4; k++)
            r[8*k +: 8] = d[8*(k % sz) +: 8];
        return r;
    endfunction

    function automatic logic [31:0] f_ld(input logic [1:0] w,
                                         input logic ext,
                                         input logic [31:0] a,
                                         input logic [31:0] rd);
        logic [31:0] v, mask;
        int sz;
        sz   = lane_size(w);
        v    = rd >> (8 * a[1:0]);
        if (sz == 4) return rd;
        mask = (32'h1 << (8 * sz)) - 32'h1;
        v    = v & mask;
        if (ext && v[8*sz-1]) v = v | ~mask;
        return v;
    endfunction

    // Starts at a negedge, holds the instruction until it leaves
    // the stage, returns at the following negedge.
    task automatic issue(input logic rd, input logic wr,
                         input logic ext, input logic [1:0] w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] pc, input logic [4:0] rg,
                         input int waits, input logic [31:0] rdata);
        int cyc;
        logic done;
        mem_valid = 1'b1;
        mem_read  = rd;
        mem_write = wr;
        mem_extend = ext;
        mem_width = w;
        mem_data0 = a;
        mem_data1 = d;
        mem_pc    = pc;
        wb_reg    = rg;
        o_stalls  = 0;
        o_wbv_stall = 0;
        o_hung    = 1'b0;
        cyc       = 0;
        forever begin
            dbus_ack = 1'b0;
            #1;
            dbus_ack   = dbus_req && (cyc == waits);
            dbus_rdata = (cyc == waits) ? rdata : $urandom;
            #1;
            if (cyc == 0) begin
                o_req   = dbus_req;
                o_we    = dbus_we;
                o_be    = dbus_be;
                o_wdata = dbus_wdata;
                o_addr  = dbus_addr;
                o_fv    = mem_forward_valid;
                o_fd    = mem_forward_data;
            end
            done = !mem_stall;
            if (mem_stall) o_stalls++;
            @(posedge clk);
            #1;
            if (done) break;
            if (wb_valid) o_wbv_stall++;
            if (cyc == 40) begin
                o_hung = 1'b1;
                break;
            end
            @(negedge clk);
            cyc++;
        end
        o_wbv  = wb_valid;
        o_wpc  = wb_pc;
        o_wdat = wb_data;
        o_wreg = wb_reg_r;
        o_wf   = wb_fault;
        @(negedge clk);
        dbus_ack = 1'b0;
    endtask

    task automatic idle_check(input string name);
        mem_valid = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (wb_valid !== 1'b0) begin
            bad++;
            $display("FAIL %s extra_wb got=%b want=0", name, wb_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        mem_valid = 0; mem_read = 0; mem_write = 0;
        mem_extend = 0; mem_width = 0; wb_reg = 0;
        mem_pc = 0; mem_data0 = 0; mem_data1 = 0;
        dbus_ack = 0; dbus_rdata = 0;
        @(posedge clk);
        #1;
        total++;
        if ({wb_valid, wb_pc, wb_data, wb_reg_r, wb_fault}
                !== '0) begin
            bad++;
            $display("FAIL reset_wb got=%b/%h/%h/%h/%h want=0",
                     wb_valid, wb_pc, wb_data, wb_reg_r, wb_fault);
        end
        total++;
        if ({dbus_req, mem_stall} !== 2'b00) begin
            bad++;
            $display("FAIL reset_bus got=%b%b want=00",
                     dbus_req, mem_stall);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_word_store();
        issue(0, 1, 0, 2'd2, 32'h100, 32'hDEADBEEF,
              32'h1000, 5'd0, 0, 32'h0);
        total++;
        if ({o_req, o_we, o_be} !== 6'b11_1111) begin
            bad++;
            $display("FAIL ws_bus got=%b%b%b want=111111",
                     o_req, o_we, o_be);
        end
        total++;
        if (o_wdata !== 32'hDEADBEEF || o_addr !== 32'h100) begin
            bad++;
            $display("FAIL ws_data got=%h@%h want=deadbeef@100",
                     o_wdata, o_addr);
        end
        total++;
        if (o_stalls !== 0 || o_wbv !== 1'b1
                || o_wdat !== 32'h100 || o_wpc !== 32'h1000) begin
            bad++;
            $display("FAIL ws_wb got=%0d/%b/%h/%h want=0/1/100/1000",
                     o_stalls, o_wbv, o_wdat, o_wpc);
        end
        idle_check("ws");
    endtask

    task automatic test_byte_load();
        logic [31:0] want[2];
        want[0] = 32'hFFFFFF80;
        want[1] = 32'h00000080;
        for (int i = 0; i < 2; i++) begin
            issue(1, 0, (i == 0), 2'd0, 32'h203, 32'h0,
                  32'h2000 + i, 5'd5, 3, 32'h80FF1234);
            total++;
            if (o_stalls !== 3 || o_be !== 4'b1000
                    || o_addr !== 32'h200 || o_we !== 1'b0) begin
                bad++;
                $display("FAIL bl_bus got=%0d/%b/%h want=3/1000/200",
                         o_stalls, o_be, o_addr);
            end
            total++;
            if (o_wdat !== want[i] || o_wreg !== 5'd5
                    || o_wf !== 2'd0 || o_wbv_stall != 0) begin
                bad++;
                $display("FAIL bl_wb got=%h/%0d/%0d want=%h/5/0",
                         o_wdat, o_wreg, o_wf, want[i]);
            end
            idle_check("bl");
        end
    endtask

    task automatic test_half();
        issue(0, 1, 0, 2'd1, 32'h12, 32'h0000ABCD,
              32'h3000, 5'd0, 1, 32'h0);
        total++;
        if (o_be !== 4'b1100 || o_wdata !== 32'hABCDABCD) begin
            bad++;
            $display("FAIL hs got=%b/%h want=1100/abcdabcd",
                     o_be, o_wdata);
        end
        issue(1, 0, 1, 2'd1, 32'h12, 32'h0,
              32'h3004, 5'd9, 0, 32'h7FFF0000);
        total++;
        if (o_wdat !== 32'h00007FFF || o_stalls !== 0) begin
            bad++;
            $display("FAIL hl got=%h/%0d want=00007fff/0",
                     o_wdat, o_stalls);
        end
        idle_check("half");
    endtask

    task automatic test_misaligned();
        issue(1, 0, 0, 2'd2, 32'h101, 32'h0,
              32'h4000, 5'd7, 0, 32'h0);
        total++;
        if (o_req !== 1'b0 || o_stalls !== 0) begin
            bad++;
            $display("FAIL mis_bus got=%b/%0d want=0/0",
                     o_req, o_stalls);
        end
        total++;
        if (o_wbv !== 1'b1 || o_wf !== 2'd1 || o_wreg !== 5'd0) begin
            bad++;
            $display("FAIL mis_wb got=%b/%0d/%0d want=1/1/0",
                     o_wbv, o_wf, o_wreg);
        end
        idle_check("mis");
    endtask

    task automatic test_timeout();
        issue(1, 0, 0, 2'd2, 32'h300, 32'h0,
              32'h5000, 5'd4, 1000, 32'h0);
        total++;
        if (o_hung || o_stalls !== TMO || o_wf !== 2'd2
                || o_wdat !== 32'h0 || o_wreg !== 5'd0) begin
            bad++;
            $display("FAIL tmo got=%0d/%0d/%h/%0d want=%0d/2/0/0",
                     o_stalls, o_wf, o_wdat, o_wreg, TMO);
        end
        issue(1, 0, 0, 2'd2, 32'h304, 32'h0,
              32'h5004, 5'd4, 1, 32'h12345678);
        total++;
        if (o_stalls !== 1 || o_wf !== 2'd0
                || o_wdat !== 32'h12345678 || o_wreg !== 5'd4) begin
            bad++;
            $display("FAIL tmo_next got=%0d/%0d/%h want=1/0/12345678",
                     o_stalls, o_wf, o_wdat);
        end
        idle_check("tmo");
    endtask

    task automatic test_reset_busy();
        mem_valid = 1; mem_read = 1; mem_write = 0;
        mem_width = 2'd2; mem_data0 = 32'h400;
        mem_pc = 32'h6000; wb_reg = 5'd3;
        dbus_ack = 0;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        total++;
        if ({wb_valid, wb_pc, wb_data, wb_fault} !== '0) begin
            bad++;
            $display("FAIL rst_busy got=%b/%h/%h/%0d want=0",
                     wb_valid, wb_pc, wb_data, wb_fault);
        end
        mem_valid = 1'b0;
        mem_read  = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        // A fresh timeout run shows the counter restarted at zero.
        issue(1, 0, 0, 2'd2, 32'h404, 32'h0,
              32'h6004, 5'd3, 1000, 32'h0);
        total++;
        if (o_stalls !== TMO || o_wf !== 2'd2) begin
            bad++;
            $display("FAIL rst_idle got=%0d/%0d want=%0d/2",
                     o_stalls, o_wf, TMO);
        end
        idle_check("rstb");
    endtask

    task automatic test_back_to_back();
        issue(0, 0, 0, 2'd0, 32'h55, 32'h0,
              32'h7000, 5'd3, 0, 32'h0);
        total++;
        if (o_fv !== 1'b1 || o_fd !== 32'h55 || o_stalls !== 0
                || o_wbv !== 1'b1 || o_wdat !== 32'h55
                || o_wreg !== 5'd3) begin
            bad++;
            $display("FAIL b2b_alu got=%b/%h/%0d/%b/%h/%0d",
                     o_fv, o_fd, o_stalls, o_wbv, o_wdat, o_wreg);
        end
        issue(1, 0, 0, 2'd2, 32'h40, 32'h0,
              32'h7004, 5'd6, 2, 32'hCAFEF00D);
        total++;
        if (o_fv !== 1'b0 || o_stalls !== 2 || o_wbv_stall != 0
                || o_wdat !== 32'hCAFEF00D || o_wpc !== 32'h7004) begin
            bad++;
            $display("FAIL b2b_ld got=%b/%0d/%0d/%h want=0/2/0/cafef00d",
                     o_fv, o_stalls, o_wbv_stall, o_wdat);
        end
        idle_check("b2b");
    endtask

    task automatic test_random();
        logic rd, wr, ext, mis, req, tmo;
        logic [1:0] w, ef;
        logic [31:0] a, d, rdat, pc, ewd;
        logic [4:0] rg;
        int waits, kind, est;
        for (int i = 0; i < 60; i++) begin
            kind = $urandom_range(0, 2);
            rd   = (kind == 1);
            wr   = (kind == 2);
            ext  = $urandom_range(0, 1);
            w    = 2'($urandom_range(0, 3));
            a    = $urandom;
            if ($urandom_range(0, 3) != 0 && w != 2'd3)
                a = a & ~(lane_size(w) - 1);
            d    = $urandom;
            rdat = $urandom;
            pc   = $urandom;
            rg   = 5'($urandom);
            waits = $urandom_range(0, TMO + 2);
            mis = (rd | wr) && f_mis(w, a);
            req = (rd | wr) && !mis;
            tmo = req && (waits > TMO);
            est = !req ? 0 : (waits < TMO ? waits : TMO);
            ef  = mis ? 2'd1 : tmo ? 2'd2 : 2'd0;
            ewd = rd ? f_ld(w, ext, a, rdat) : a;
            if (ef != 0) ewd = 32'h0;
            issue(rd, wr, ext, w, a, d, pc, rg, waits, rdat);
            total++;
            if (o_req !== req || o_stalls !== est || o_hung) begin
                bad++;
                $display("FAIL rnd%0d_flow got=%b/%0d want=%b/%0d",
                         i, o_req, o_stalls, req, est);
            end
            total++;
            if (o_fv !== !rd || o_fd !== a) begin
                bad++;
                $display("FAIL rnd%0d_fwd got=%b/%h want=%b/%h",
                         i, o_fv, o_fd, !rd, a);
            end
            if (req) begin
                total++;
                if (o_be !== f_be(w, a) || o_we !== wr
                        || o_addr !== {a[31:2], 2'b00}) begin
                    bad++;
                    $display("FAIL rnd%0d_be got=%b/%b want=%b/%b",
                             i, o_be, o_we, f_be(w, a), wr);
                end
            end
            if (req && wr) begin
                total++;
                if (o_wdata !== f_wd(w, d)) begin
                    bad++;
                    $display("FAIL rnd%0d_wd got=%h want=%h",
                             i, o_wdata, f_wd(w, d));
                end
            end
            total++;
            if (o_wbv !== 1'b1 || o_wf !== ef || o_wpc !== pc
                    || o_wreg !== (ef != 0 ? 5'd0 : rg)) begin
                bad++;
                $display("FAIL rnd%0d_wb got=%b/%0d/%h/%0d want=1/%0d/%h",
                         i, o_wbv, o_wf, o_wpc, o_wreg, ef, pc);
            end
            if (!mis) begin
                total++;
                if (o_wdat !== ewd) begin
                    bad++;
                    $display("FAIL rnd%0d_data got=%h want=%h",
                             i, o_wdat, ewd);
                end
            end
            if ($urandom_range(0, 2) == 0) idle_check("rnd");
        end
        idle_check("rnd_end");
    endtask

    initial begin
        test_reset();
        test_word_store();
        test_byte_load();
        test_half();
        test_misaligned();
        test_timeout();
        test_reset_busy();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
